lsu_rmw: RTL and testbench
==========================

# lsu_rmw

Load/store unit between the single-cycle core's data port and a word-addressed synchronous data RAM. It accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests and stalls the core until each access completes. Loads are returned byte-lane aligned and sign/zero extended. Sub-word stores are done as a read-modify-write so the RAM only ever sees whole-word writes.

## Interface
- SIZE, 32: data width; fixed at 32 (lane logic is 32-bit only)
- ADDR_WIDTH, 10: RAM word-address width
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  reset; asynchronous, active-high
- req_valid  in  1  core presents a memory instruction; held stable while stall=1
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  instruction funct3 (size/sign)
- req_addr  in  SIZE  byte address (ALU result)
- req_wdata  in  SIZE  store data (rs2)
- stall  out  1  core must hold PC/instruction
- rsp_valid  out  1  one-cycle pulse: access finished
- rsp_rdata  out  SIZE  load result, valid with rsp_valid
- misaligned  out  1  with rsp_valid: access was misaligned and suppressed
- mem_addr  out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]
- mem_we  out  1  RAM write enable
- mem_wdata  out  SIZE  RAM write word
- mem_rdata  in  SIZE  RAM read data; one cycle after mem_addr

## Operation
- States: IDLE, RD, WR, MERGE, DONE.
- Request capture:
  - req_valid is sampled only in IDLE.
  - On acceptance, addr/funct3/wdata/we are registered.
- Next state from IDLE:
  - misaligned → DONE
  - load → RD
  - SW → WR
  - SB/SH → RD
- RD: drives mem_addr with mem_we=0. Next state: load → DONE, SB/SH → MERGE.
- MERGE: mem_rdata is valid.
  - Replace the addressed lane(s) with req_wdata[7:0] or [15:0].
  - Drive mem_we=1 with the merged word at the same mem_addr.
  - Next state → DONE.
- WR: mem_we=1, mem_wdata=req_wdata. Next state → DONE.
- DONE:
  - rsp_valid=1.
  - For loads, rsp_rdata is the selected lane of the mem_rdata captured in RD+1.
  - Next state → IDLE unconditionally. The still-present req_valid is not re-accepted.
- Lane select: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign extend.
  - LBU/LHU zero extend.
  - LW passes the whole word.
- Misaligned rules:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠0 is misaligned.
  - No RAM access occurs. rsp_rdata=0, misaligned=1 in DONE.
- Unsupported funct3 (011, 110, 111): treated as misaligned (suppressed, flagged).
- Address bits above ADDR_WIDTH+1 are ignored (wrap).

## Timing
- stall = (IDLE & req_valid) | state∈{RD, WR, MERGE}. It is combinational from req_valid in IDLE and low in DONE.
- Latency in cycles, acceptance cycle to DONE:
  - load: 2
  - SW: 2
  - SB/SH: 3
  - misaligned: 1
- mem_we is high for exactly one cycle per store and never for loads or misaligned requests.
- Reset values:
  - state=IDLE
  - stall follows req_valid
  - rsp_valid=0, rsp_rdata=0, misaligned=0
  - mem_we=0, mem_addr=0, mem_wdata=0
- Reset mid-operation:
  - The state returns to IDLE asynchronously and mem_we drops immediately.
  - A partially merged store is abandoned; the RAM is unchanged unless the MERGE edge already occurred.
- Back-to-back requests: the next request can be accepted in the cycle after DONE.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_t
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
- One combinational sub-module, lsu_align, does lane extraction/extension (load) and lane merge (store). It is shared by the RD/DONE and MERGE paths.

## Test plan
- LW at 0x0000_0008, RAM word 2 = 0xDEAD_BEEF → stall high for 2 cycles, then rsp_valid with rsp_rdata=0xDEAD_BEEF, mem_we never high.
- LB at 0x0000_0007, then LBU at the same address, RAM word 1 = 0x80xx_xxxx → rsp_rdata=0xFFFF_FF80, then 0x0000_0080.
- SB 0x55 at 0x0000_0005, RAM word 1 = 0x1122_3344:
  - read issued at word 1
  - MERGE writes 0x1122_5544 with mem_we high one cycle
  - total stall 3 cycles
- SH at 0x0000_0003 → misaligned=1 after 1 cycle, mem_we and RAM unchanged.
- Assert RESET during MERGE of SH 0xAAAA at 0x2 → mem_we drops the same cycle, state IDLE, rsp_valid=0.
- Two back-to-back SW requests (0x10←1, 0x14←2) → each is accepted once, each has exactly one write pulse, and both RAM words are correct.

Source files
------------

// File: rtl/lsu_rmw_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StMerge,
        StDone
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsupported encodings, and unsigned variants used as stores, are flagged like misalignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic we);
        logic res;
        case (f3)
            F3_B:    res = 1'b0;
            F3_H:    res = lo[0];
            F3_W:    res = (lo != 2'b00);
            F3_BU:   res = we;
            F3_HU:   res = we | lo[0];
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response and RAM-side signals of the load/store unit.
interface lsu_rmw_if #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [SIZE-1:0]       req_addr;
    logic [SIZE-1:0]       req_wdata;
    logic                  stall;
    logic                  rsp_valid;
    logic [SIZE-1:0]       rsp_rdata;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [SIZE-1:0]       mem_wdata;
    logic [SIZE-1:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, misaligned, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output stall, rsp_valid, rsp_rdata, misaligned, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_rmw_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{byte_sel, 3'b000} +: 8];
        lane_h = byte_sel[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase

        merge_data = rdata;
        if (funct3 == F3_B) begin
            merge_data[{byte_sel, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            if (byte_sel[1]) merge_data[31:16] = wdata;
            else             merge_data[15:0]  = wdata;
        end
    end
endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: stalls the core per access, does sub-word stores as read-modify-write.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic      CLK,
    input  logic      RESET,
    lsu_rmw_if.slave  bus
);
    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [SIZE-1:0]       wdata_q;
    logic                  we_q;
    logic                  accept;
    logic                  mis_req;
    logic                  mis_q;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;

    assign accept  = (state_q == StIdle) && bus.req_valid;
    assign mis_req = is_misaligned(bus.req_funct3, bus.req_addr[1:0], bus.req_we);
    assign mis_q   = is_misaligned(funct3_q, addr_q[1:0], we_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= bus.req_addr[ADDR_WIDTH+1:0];
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
                we_q     <= bus.req_we;
            end
        end
    end

    // Shared by the MERGE path and the DONE load path; both see mem_rdata from the RD read.
    lsu_align u_align (
        .funct3     (funct3_q),
        .byte_sel   (addr_q[1:0]),
        .rdata      (bus.mem_rdata),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign bus.mem_addr = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        state_d        = state_q;
        bus.stall      = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_rdata  = '0;
        bus.misaligned = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = '0;
        unique case (state_q)
            StIdle: begin
                bus.stall = bus.req_valid;
                if (bus.req_valid) begin
                    if (mis_req)                     state_d = StDone;
                    else if (!bus.req_we)            state_d = StRd;
                    else if (bus.req_funct3 == F3_W) state_d = StWr;
                    else                             state_d = StRd;
                end
            end
            StRd: begin
                bus.stall = 1'b1;
                state_d   = we_q ? StMerge : StDone;
            end
            StMerge: begin
                bus.stall     = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = merge_data;
                state_d       = StDone;
            end
            StWr: begin
                bus.stall     = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = wdata_q;
                state_d       = StDone;
            end
            StDone: begin
                bus.rsp_valid  = 1'b1;
                bus.misaligned = mis_q;
                if (!we_q && !mis_q) bus.rsp_rdata = load_data;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a synchronous word RAM model.
module tb_lsu_rmw;
    localparam int unsigned SIZE = 32;
    localparam int unsigned AW   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_rmw_if #(.SIZE(SIZE), .ADDR_WIDTH(AW)) bus ();

    lsu_rmw #(.SIZE(SIZE), .ADDR_WIDTH(AW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    logic [31:0] ram [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)           ram[pre_addr] <= pre_data;
        else if (bus.mem_we)  ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic idle(input string tag);
        bus.req_valid = 1'b0;
        #1;
        check({tag, "_idle_stall"}, {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
    endtask

    // Presents one request at a negedge and watches it until the rsp_valid cycle.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int n_stall, output int n_we, output logic [31:0] rdata,
                          output logic mis, output logic [31:0] wr_word,
                          output logic [9:0] wr_addr, output logic [9:0] rd_addr);
        bit done = 1'b0;
        n_stall = 0; n_we = 0; rdata = '0; mis = 1'b0;
        wr_word = '0; wr_addr = '0; rd_addr = '0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        #1;
        for (int c = 0; c < 10 && !done; c++) begin
            if (bus.mem_we) begin
                n_we++; wr_word = bus.mem_wdata; wr_addr = bus.mem_addr;
            end
            if (bus.rsp_valid) begin
                rdata = bus.rsp_rdata; mis = bus.misaligned; done = 1'b1;
            end else begin
                if (bus.stall) n_stall++;
                if (n_stall == 2 && bus.stall && !bus.mem_we) rd_addr = bus.mem_addr;
                @(negedge clk);
                #1;
            end
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    int          ns, nw;
    logic [31:0] rd, ww;
    logic        ms;
    logic [9:0]  wa, ra;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        #1;
        check("rst_stall",      {31'b0, bus.stall},      32'd0);
        check("rst_rsp_valid",  {31'b0, bus.rsp_valid},  32'd0);
        check("rst_rsp_rdata",  bus.rsp_rdata,           32'd0);
        check("rst_misaligned", {31'b0, bus.misaligned}, 32'd0);
        check("rst_mem_we",     {31'b0, bus.mem_we},     32'd0);
        check("rst_mem_addr",   {22'b0, bus.mem_addr},   32'd0);
        check("rst_mem_wdata",  bus.mem_wdata,           32'd0);
        bus.req_valid = 1'b1;
        #1;
        check("rst_stall_follows", {31'b0, bus.stall}, 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        poke(10'd2, 32'hDEAD_BEEF);
        poke(10'd1, 32'h8011_2233);

        do_req("lw", 1'b0, 3'b010, 32'h0000_0008, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("lw_stall", ns, 2);
        check("lw_we", nw, 0);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_rdaddr", {22'b0, ra}, 32'd2);
        idle("lw");

        do_req("lb", 1'b0, 3'b000, 32'h0000_0007, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        check("lb_we", nw, 0);
        idle("lb");
        do_req("lbu", 1'b0, 3'b100, 32'h0000_0007, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("lbu_rdata", rd, 32'h0000_0080);
        idle("lbu");
        do_req("lh", 1'b0, 3'b001, 32'h0000_0006, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("lh_rdata", rd, 32'hFFFF_8011);
        idle("lh");
        do_req("lhu", 1'b0, 3'b101, 32'h0000_0004, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("lhu_rdata", rd, 32'h0000_2233);
        idle("lhu");
        do_req("wrap", 1'b0, 3'b010, 32'h1000_0008, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("wrap_rdata", rd, 32'hDEAD_BEEF);
        idle("wrap");

        poke(10'd1, 32'h1122_3344);
        do_req("sb", 1'b1, 3'b000, 32'h0000_0005, 32'h55, ns, nw, rd, ms, ww, wa, ra);
        check("sb_stall", ns, 3);
        check("sb_we", nw, 1);
        check("sb_rdaddr", {22'b0, ra}, 32'd1);
        check("sb_wraddr", {22'b0, wa}, 32'd1);
        check("sb_word", ww, 32'h1122_5544);
        check("sb_mis", {31'b0, ms}, 32'd0);
        idle("sb");
        check("sb_ram", ram[1], 32'h1122_5544);

        poke(10'd0, 32'hCAFE_F00D);
        do_req("sh_mis", 1'b1, 3'b001, 32'h0000_0003, 32'hBEEF, ns, nw, rd, ms, ww, wa, ra);
        check("sh_mis_flag", {31'b0, ms}, 32'd1);
        check("sh_mis_stall", ns, 1);
        check("sh_mis_we", nw, 0);
        check("sh_mis_rdata", rd, 32'd0);
        idle("sh_mis");
        check("sh_mis_ram", ram[0], 32'hCAFE_F00D);
        do_req("lw_mis", 1'b0, 3'b010, 32'h0000_000A, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("lw_mis_flag", {31'b0, ms}, 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        idle("lw_mis");
        do_req("f3_011", 1'b0, 3'b011, 32'h0000_0008, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("f3_011_flag", {31'b0, ms}, 32'd1);
        check("f3_011_stall", ns, 1);
        idle("f3_011");

        // Reset lands in the MERGE cycle of SH 0xAAAA at 0x2.
        poke(10'd0, 32'h1234_5678);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h0000_0002; bus.req_wdata = 32'h0000_AAAA;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rmw_merge_we", {31'b0, bus.mem_we}, 32'd1);
        check("rmw_merge_word", bus.mem_wdata, 32'hAAAA_5678);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        check("rmw_rst_we", {31'b0, bus.mem_we}, 32'd0);
        check("rmw_rst_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        check("rmw_rst_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rmw_rst_ram", ram[0], 32'h1234_5678);
        do_req("post_rst", 1'b0, 3'b010, 32'h0000_0000, 32'h0, ns, nw, rd, ms, ww, wa, ra);
        check("post_rst_rdata", rd, 32'h1234_5678);
        idle("post_rst");

        poke(10'd4, 32'h0);
        poke(10'd5, 32'h0);
        do_req("sw1", 1'b1, 3'b010, 32'h0000_0010, 32'd1, ns, nw, rd, ms, ww, wa, ra);
        check("sw1_stall", ns, 2);
        check("sw1_we", nw, 1);
        check("sw1_word", ww, 32'd1);
        do_req("sw2", 1'b1, 3'b010, 32'h0000_0014, 32'd2, ns, nw, rd, ms, ww, wa, ra);
        check("sw2_stall", ns, 2);
        check("sw2_we", nw, 1);
        check("sw2_wraddr", {22'b0, wa}, 32'd5);
        idle("sw2");
        check("sw_ram4", ram[4], 32'd1);
        check("sw_ram5", ram[5], 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
